// File: rtl/buf_word_pack_if.sv
// Stream-in / packet-out bus for buf_word_pack.
// Optional s_last exists only when BUF_WORD_PACK_LAST_EN is defined.
interface buf_word_pack_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
);
  localparam int CNT_W = $clog2(LANES + 1);

  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_ready;
`ifdef BUF_WORD_PACK_LAST_EN
  logic                    s_last;
`endif
  logic [LANES*DATA_W-1:0] m_lanes;
  logic                    m_valid;
  logic                    m_ready;
  logic [CNT_W-1:0]        m_count;

`ifdef BUF_WORD_PACK_LAST_EN
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_lanes, m_valid, m_count
  );
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_lanes, m_valid, m_count
  );
`else
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_lanes, m_valid, m_count
  );
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_lanes, m_valid, m_count
  );
`endif
endinterface

// File: rtl/buf_word_pack.sv
// Packs LANES serial words into one wide packet, held until the consumer takes it.
// Define BUF_WORD_PACK_LAST_EN to enable s_last short-packet flush.
module buf_word_pack #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
) (
  input  logic          clk,
  input  logic          reset,
  buf_word_pack_if.slave bus
);
  localparam int PTR_W = $clog2(LANES);
  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [PTR_W-1:0]               r_ptr;
  logic [CNT_W-1:0]               r_count;
  logic [LANES-1:0][DATA_W-1:0]   r_lanes;

  logic w_accept;
  logic w_take;
  logic w_close;
  logic w_s_ready;
  logic w_m_valid;

  function automatic logic [CNT_W-1:0] lane_count(input logic [PTR_W-1:0] ptr);
    return CNT_W'(ptr) + CNT_W'(1);
  endfunction

  assign w_accept = bus.s_valid && (r_state == FILL);
  assign w_take   = bus.m_ready && (r_state == HOLD);
`ifdef BUF_WORD_PACK_LAST_EN
  assign w_close  = w_accept && ((r_ptr == LAST_PTR) || bus.s_last);
`else
  assign w_close  = w_accept && (r_ptr == LAST_PTR);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_close) w_next_state = HOLD;
      HOLD:    if (bus.m_ready) w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    w_s_ready = (r_state == FILL);
    w_m_valid = (r_state == HOLD);
  end

  // Taking the packet wipes it so unwritten lanes of the next one read 0;
  // the closing word leaves ptr in range and only latches the lane count.
  always_ff @(posedge clk) begin
    if (reset || w_take) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_lanes <= '0;
    end else if (w_accept) begin
      r_lanes[r_ptr] <= bus.s_data;
      if (w_close) r_count <= lane_count(r_ptr);
      else         r_ptr   <= r_ptr + PTR_W'(1);
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_lanes = r_lanes;
  assign bus.m_count = r_count;
endmodule

// File: tb/tb_buf_word_pack.sv
// Directed bench for buf_word_pack (8x32 instance) plus a randomised 4x16 instance.
module tb_buf_word_pack;
  localparam int DW  = 32;
  localparam int LN  = 8;
  localparam int DWB = 16;
  localparam int LNB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  buf_word_pack_if #(.DATA_W(DW),  .LANES(LN))  bus_a ();
  buf_word_pack_if #(.DATA_W(DWB), .LANES(LNB)) bus_b ();

  buf_word_pack #(.DATA_W(DW), .LANES(LN)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );
  buf_word_pack #(.DATA_W(DWB), .LANES(LNB)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // lane i = base+i for i < n, remaining lanes 0
  function automatic logic [255:0] seq8(input int base, input int n);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[32*i +: 32] = 32'(base + i);
    return v;
  endfunction

  task automatic push_a(input int d);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = 32'(d);
    @(negedge clk);
    bus_a.s_valid = 1'b0;
  endtask

  task automatic push_seq(input int base, input int n);
    for (int i = 0; i < n; i++) push_a(base + i);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " s_ready"}, 256'(bus_a.s_ready), 256'(1));
    chk({tag, " m_valid"}, 256'(bus_a.m_valid), 256'(0));
    chk({tag, " m_lanes"}, 256'(bus_a.m_lanes), 256'(0));
    chk({tag, " m_count"}, 256'(bus_a.m_count), 256'(0));
  endtask

  task automatic chk_hold_a(input string tag, input logic [255:0] lanes, input int cnt);
    chk({tag, " m_valid"}, 256'(bus_a.m_valid), 256'(1));
    chk({tag, " s_ready"}, 256'(bus_a.s_ready), 256'(0));
    chk({tag, " m_lanes"}, 256'(bus_a.m_lanes), lanes);
    chk({tag, " m_count"}, 256'(bus_a.m_count), 256'(cnt));
  endtask

  task automatic take_a(input string tag);
    bus_a.m_ready = 1'b1;
    @(negedge clk);
    bus_a.m_ready = 1'b0;
    chk_idle_a(tag);
  endtask

  initial begin
    int          pkts;
    int          cyc;
    logic [15:0] q[$];
    logic [63:0] expv;

    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.m_ready = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.m_ready = 1'b0;
`ifdef BUF_WORD_PACK_LAST_EN
    bus_a.s_last = 1'b0;
    bus_b.s_last = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_idle_a("reset");

    // back-to-back full packet, consumer always ready
    bus_a.m_ready = 1'b1;
    push_seq(1, 7);
    chk("pre-last m_valid", 256'(bus_a.m_valid), 256'(0));
    push_a(8);
    chk_hold_a("full", seq8(1, 8), 8);
    @(negedge clk);
    bus_a.m_ready = 1'b0;
    chk_idle_a("full taken");

    // consumer stalls while a new word is pending
    push_seq(11, 8);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = 32'd99;
    repeat (5) begin
      chk_hold_a("stall", seq8(11, 8), 8);
      @(negedge clk);
    end
    bus_a.m_ready = 1'b1;
    @(negedge clk);
    chk_idle_a("release");
    @(negedge clk);
    bus_a.s_valid = 1'b0;
    bus_a.m_ready = 1'b0;
    chk("pending lane0", 256'(bus_a.m_lanes), seq8(99, 1));
    push_seq(100, 7);
    chk_hold_a("pending pkt", seq8(99, 8), 8);
    take_a("pending taken");

    // reset discards a partial packet
    push_seq(1, 3);
    chk("partial lanes", 256'(bus_a.m_lanes), seq8(1, 3));
    reset = 1'b1;
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = 32'd77;
    @(negedge clk);
    reset = 1'b0;
    bus_a.s_valid = 1'b0;
    chk_idle_a("mid reset");
    push_seq(21, 8);
    chk_hold_a("after reset", seq8(21, 8), 8);
    take_a("after reset taken");

    // m_ready in FILL and idle s_valid leave state alone
    push_seq(41, 2);
    bus_a.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus_a.m_ready = 1'b0;
    chk("idle lanes", 256'(bus_a.m_lanes), seq8(41, 2));
    chk("idle m_valid", 256'(bus_a.m_valid), 256'(0));
    push_seq(43, 6);
    chk_hold_a("gap pkt", seq8(41, 8), 8);

    // reset coincides with the take handshake
    reset = 1'b1;
    bus_a.m_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_a("reset+take");
    repeat (2) @(negedge clk);
    bus_a.m_ready = 1'b0;
    chk_idle_a("no duplicate");

`ifdef BUF_WORD_PACK_LAST_EN
    push_a(32'hA);
    push_a(32'hB);
    bus_a.s_last = 1'b1;
    push_a(32'hC);
    bus_a.s_last = 1'b0;
    chk_hold_a("short", seq8(10, 3), 3);
    take_a("short taken");
    push_seq(50, 7);
    bus_a.s_last = 1'b1;
    push_a(57);
    bus_a.s_last = 1'b0;
    chk_hold_a("last at end", seq8(50, 8), 8);
    take_a("last at end taken");
`endif

    // 4x16 instance: random valid/ready, packets checked against a word queue
    pkts = 0;
    cyc  = 0;
    while (pkts < 100 && cyc < 20000) begin
      bus_b.s_valid = 1'($urandom_range(0, 1));
      bus_b.s_data  = 16'($urandom);
      bus_b.m_ready = ($urandom_range(0, 3) != 0);
      if (bus_b.s_valid && bus_b.s_ready) q.push_back(bus_b.s_data);
      if (bus_b.m_valid && bus_b.m_ready) begin
        expv = '0;
        for (int i = 0; i < LNB; i++)
          if (q.size() > 0) expv[16*i +: 16] = q.pop_front();
        chk("rand lanes", 256'(bus_b.m_lanes), 256'(expv));
        chk("rand count", 256'(bus_b.m_count), 256'(LNB));
        pkts++;
      end
      @(negedge clk);
      cyc++;
    end
    bus_b.s_valid = 1'b0;
    bus_b.m_ready = 1'b0;
    chk("rand packets", 256'(pkts), 256'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
